button_events: RTL and testbench
================================

// Module: button_events
// PURPOSE
//  Converts the clean, debounced level produced by debounce into discrete button events.
//  Outputs: press, release, long-press and auto-repeat pulses, plus a registered pressed level.
//  Sits directly downstream of debounce (o_sig -> i_sig) in the board-level input path.
//  Its pulses feed memory-mapped GPIO/IRQ status bits.
// PARAMETERS
//  HOLD_CYCLES    1000000  clocks of continuous press before o_long fires; must be >= 2
//  REPEAT_CYCLES  250000   clocks between o_repeat pulses after o_long; must be >= 1
//  ACTIVE_LOW     1'b1     1: i_sig==0 means pressed; 0: i_sig==1 means pressed
// PORTS
//  i_clk        in   1  system clock, all logic on posedge
//  i_rst        in   1  asynchronous, active-high reset
//  i_sig        in   1  debounced button level, synchronous to i_clk
//  i_repeat_en  in   1  enables auto-repeat while held, sampled every clock
//  o_pressed    out  1  registered pressed level
//  o_press      out  1  one-cycle pulse on press
//  o_release    out  1  one-cycle pulse on release
//  o_long       out  1  one-cycle pulse when the hold threshold is reached
//  o_repeat     out  1  one-cycle pulse per repeat period after o_long
// BEHAVIOUR
//  - Reset (async, high): state=IDLE, counter=0, every output 0.
//    o_pressed reset value is 0 regardless of ACTIVE_LOW.
//  - w_act = i_sig ^ ACTIVE_LOW. All outputs are registered; there is no combinational input->output path.
//  - FSM states: IDLE, PRESSED, HELD.
//  - IDLE: at edge E0 where w_act==1, go to PRESSED, cnt<=0, o_press<=1, o_pressed<=1.
//  - PRESSED, w_act==1: cnt++ each edge.
//    At the edge where cnt==HOLD_CYCLES-1 (edge E0+HOLD_CYCLES): o_long<=1, go to HELD, cnt<=0.
//  - HELD, w_act==1, i_repeat_en==1: cnt++.
//    At cnt==REPEAT_CYCLES-1: o_repeat<=1, cnt<=0.
//    Pulses therefore land at E0+HOLD_CYCLES+k*REPEAT_CYCLES, k>=1.
//  - HELD, i_repeat_en==0: cnt held at 0, no o_repeat.
//    Re-enabling starts a full REPEAT_CYCLES period.
//  - PRESSED or HELD, w_act==0 at edge Er: o_release<=1, o_pressed<=0, go to IDLE, cnt<=0.
//  - Release on the threshold edge: release wins. o_release fires; o_long/o_repeat do not.
//  - Press in IDLE on the cycle right after o_release: a new o_press is legal. There is no hold-off.
//  - o_press, o_release, o_long and o_repeat are mutually exclusive in any cycle.
//    Each is high for exactly 1 cycle.
//  - Reset deasserted while the button is held: treated as a fresh press.
//    The first edge with w_act==1 gives o_press; the long timer starts from that edge.
//  - Reset mid-hold: all pulses suppressed immediately. No o_release is generated.
//  - Counter width: CNT_W = $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)). Compare by equality only; the counter never wraps.
// STRUCTURE
//  - Shared package button_pkg: typedef enum logic[1:0] btn_state_t {BTN_IDLE, BTN_PRESSED, BTN_HELD}.
//    The CNT_W helper function also lives there.
//  - Single flat module; no sub-module.
//    The top level instantiates debounce -> button_events per button.
//  - Elaboration-time check: HOLD_CYCLES>=2 and REPEAT_CYCLES>=1, else $error.
// TESTING  (bench: HOLD_CYCLES=8, REPEAT_CYCLES=4, ACTIVE_LOW=0)
//  1. Assert i_rst mid-cycle with i_sig=1 -> all outputs 0 immediately (async).
//     Deassert -> o_press 1 cycle later.
//  2. i_sig=1 for 3 clocks, then 0 -> o_press at E0 and o_release at E0+3.
//     o_long never fires; o_pressed is high for 3 cycles.
//  3. i_sig=1 for 20 clocks, i_repeat_en=1 -> o_long at E0+8.
//     o_repeat at E0+12 and E0+16; o_release at E0+20.
//  4. Same as 3 with i_repeat_en=0 -> o_long at E0+8, no o_repeat, o_release at E0+20.
//  5. Release exactly at E0+8 -> o_release only, o_long stays 0.
//     Release exactly at E0+12 with repeat enabled -> o_release only, no o_repeat.
//  6. Press/release toggled every clock for 10 clocks -> alternating o_press/o_release pulses, never two in one cycle.
//     Rerun with ACTIVE_LOW=1 and inverted stimulus -> identical output trace.

Source files
------------

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : button_pkg
//  Purpose : Shared types and helpers for the button event path.
//            - btn_state_t : event FSM state encoding
//            - cnt_w()     : hold/repeat counter width helper
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package button_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_HELD    = 2'd2
  } btn_state_t;

  // Width needed to hold counts 0 .. max(hold, repeat)-1. The counter only
  // ever reaches (threshold - 1) before being cleared, so $clog2 of the
  // larger threshold is sufficient. Floor of 1 keeps the vector legal.
  function automatic int cnt_w(input int hold_cycles, input int repeat_cycles);
    int m;
    m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_events.sv
`default_nettype none
// ============================================================================
//  Module  : button_events
//  Purpose : Turns a debounced button level into one-cycle event pulses
//            (press, release, long-press, auto-repeat) plus a registered
//            pressed level. All outputs come straight from flops.
//  Ports   : i_clk        system clock (posedge)
//            i_rst        asynchronous active-high reset
//            i_sig        debounced button level, synchronous to i_clk
//            i_repeat_en  auto-repeat enable while held
//            o_pressed    registered pressed level
//            o_press      1-cycle pulse on press
//            o_release    1-cycle pulse on release
//            o_long       1-cycle pulse when hold threshold is reached
//            o_repeat     1-cycle pulse per repeat period after o_long
//  Rev     : 1.0  initial release
// ============================================================================
module button_events
  import button_pkg::*;
#(
  parameter int   HOLD_CYCLES   = 1000000,
  parameter int   REPEAT_CYCLES = 250000,
  parameter logic ACTIVE_LOW    = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  input  logic i_repeat_en,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int CNT_W = cnt_w(HOLD_CYCLES, REPEAT_CYCLES);

  localparam logic [CNT_W-1:0] C_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

  if ((HOLD_CYCLES < 2) || (REPEAT_CYCLES < 1)) begin : g_param_check
    $error("button_events: HOLD_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             w_act;

  // Normalise polarity: w_act is 1 whenever the button is physically pressed.
  assign w_act = i_sig ^ ACTIVE_LOW;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      BTN_IDLE: begin
        if (w_act) begin
          state_d   = BTN_PRESSED;
          cnt_d     = '0;
          press_d   = 1'b1;
          pressed_d = 1'b1;
        end
      end

      // Release is tested first so it wins over a threshold hit on the same edge.
      BTN_PRESSED: begin
        if (!w_act) begin
          state_d   = BTN_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else if (cnt_q == C_HOLD_LAST) begin
          state_d = BTN_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      BTN_HELD: begin
        if (!w_act) begin
          state_d   = BTN_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else if (!i_repeat_en) begin
          // Parked at zero so re-enabling waits a full repeat period.
          cnt_d = '0;
        end else if (cnt_q == C_REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      default: begin
        state_d   = BTN_IDLE;
        cnt_d     = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= BTN_IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_pressed = pressed_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;

endmodule : button_events
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// ============================================================================
//  Module  : tb_button_events
//  Purpose : Directed self-checking bench for button_events with
//            HOLD_CYCLES=8, REPEAT_CYCLES=4. An ACTIVE_LOW=0 instance and an
//            ACTIVE_LOW=1 instance fed the inverted level are held to the
//            same expected trace.
//            Observed vector order: {pressed, press, release, long, repeat}.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_button_events;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;
  logic en  = 1'b0;

  logic pressed, press, rel, lng, rep;
  logic pressed_n, press_n, rel_n, lng_n, rep_n;
  logic [4:0] obs, obs_n;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  button_events #(
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .ACTIVE_LOW(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sig(sig), .i_repeat_en(en),
    .o_pressed(pressed), .o_press(press), .o_release(rel),
    .o_long(lng), .o_repeat(rep)
  );

  button_events #(
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .i_clk(clk), .i_rst(rst), .i_sig(~sig), .i_repeat_en(en),
    .o_pressed(pressed_n), .o_press(press_n), .o_release(rel_n),
    .o_long(lng_n), .o_repeat(rep_n)
  );

  assign obs   = {pressed, press, rel, lng, rep};
  assign obs_n = {pressed_n, press_n, rel_n, lng_n, rep_n};

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    n_checks++;
    if (obs !== 5'b00000 || obs_n !== 5'b00000)
      $display("FAIL reset_idle obs=%b obs_n=%b exp=00000", obs, obs_n);
    else n_pass++;

    rst = 1'b0;
    sig = 1'b1;
    cyc();
    n_checks++;
    if (obs !== 5'b11000 || obs_n !== 5'b11000)
      $display("FAIL reset_first_press obs=%b obs_n=%b exp=11000", obs, obs_n);
    else n_pass++;
    cyc();
    n_checks++;
    if (obs !== 5'b10000 || obs_n !== 5'b10000)
      $display("FAIL reset_holding obs=%b obs_n=%b exp=10000", obs, obs_n);
    else n_pass++;

    // Mid-cycle reset while held: outputs must clear without a clock edge.
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 5'b00000 || obs_n !== 5'b00000)
      $display("FAIL reset_async obs=%b obs_n=%b exp=00000", obs, obs_n);
    else n_pass++;
    #1 rst = 1'b0;

    // Still held after reset: next edge is a fresh press, no release.
    cyc();
    n_checks++;
    if (obs !== 5'b11000 || obs_n !== 5'b11000)
      $display("FAIL reset_repress obs=%b obs_n=%b exp=11000", obs, obs_n);
    else n_pass++;
    sig = 1'b0;
    cyc();
    n_checks++;
    if (obs !== 5'b00100 || obs_n !== 5'b00100)
      $display("FAIL reset_release obs=%b obs_n=%b exp=00100", obs, obs_n);
    else n_pass++;
    cyc();
    n_checks++;
    if (obs !== 5'b00000 || obs_n !== 5'b00000)
      $display("FAIL reset_back_idle obs=%b obs_n=%b exp=00000", obs, obs_n);
    else n_pass++;
  endtask

  // Hold for len edges (press at edge 0, release at edge len). Expected
  // event edges are supplied by the caller; -1 means "never".
  task automatic run_hold(input string name, input int len, input logic en0,
                          input int long_at, input int r1, input int r2,
                          input int en_off, input int en_on);
    logic [4:0] exp;
    en  = en0;
    sig = 1'b1;
    for (int t = 0; t <= len + 1; t++) begin
      cyc();
      exp = {(t < len), (t == 0), (t == len), (t == long_at), ((t == r1) || (t == r2))};
      n_checks++;
      if (obs !== exp)
        $display("FAIL %s t=%0d obs=%b exp=%b", name, t, obs, exp);
      else n_pass++;
      n_checks++;
      if (obs_n !== exp)
        $display("FAIL %s_al t=%0d obs=%b exp=%b", name, t, obs_n, exp);
      else n_pass++;
      if (t == len - 1) sig = 1'b0;
      if (t == en_off)  en  = 1'b0;
      if (t == en_on)   en  = 1'b1;
    end
    en = 1'b0;
  endtask

  task automatic test_short_press();
    run_hold("short", 3, 1'b1, -1, -1, -1, -1, -1);
  endtask

  task automatic test_long_repeat();
    run_hold("long_rep", 20, 1'b1, 8, 12, 16, -1, -1);
  endtask

  task automatic test_long_no_repeat();
    run_hold("long_norep", 20, 1'b0, 8, -1, -1, -1, -1);
  endtask

  task automatic test_release_on_threshold();
    run_hold("rel_at_long", 8, 1'b1, -1, -1, -1, -1, -1);
    run_hold("rel_at_rep", 12, 1'b1, 8, -1, -1, -1, -1);
  endtask

  // Repeat disabled for edges 10..13, re-enabled from edge 14: the next
  // pulse needs a full period, landing at edge 17.
  task automatic test_repeat_reenable();
    run_hold("rep_reen", 19, 1'b1, 8, 17, -1, 9, 13);
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    sig = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cyc();
      exp = (t % 2 == 0) ? 5'b11000 : 5'b00100;
      n_checks++;
      if (obs !== exp)
        $display("FAIL toggle t=%0d obs=%b exp=%b", t, obs, exp);
      else n_pass++;
      n_checks++;
      if (obs_n !== exp)
        $display("FAIL toggle_al t=%0d obs=%b exp=%b", t, obs_n, exp);
      else n_pass++;
      sig = (t < 9) ? ~sig : 1'b0;
    end
    cyc();
    n_checks++;
    if (obs !== 5'b00000 || obs_n !== 5'b00000)
      $display("FAIL toggle_end obs=%b obs_n=%b exp=00000", obs, obs_n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_long_no_repeat();
    test_release_on_threshold();
    test_repeat_reenable();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_button_events
`default_nettype wire
